// File: rtl/uart_flow_pkg.sv
// Shared definitions for the in-band UART flow-control link (encoder and decoder ends).
package uart_flow_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned COUNT_W = 16;

  localparam logic [BYTE_W-1:0] STOP_CODE  = 8'hFF;
  localparam logic [BYTE_W-1:0] START_CODE = 8'hFE;
  localparam logic [BYTE_W-1:0] ESC_CODE   = 8'hFD;

  typedef enum logic {
    FLOW_RUN    = 1'b0,
    FLOW_PAUSED = 1'b1
  } flow_state_e;

endpackage

// File: rtl/flow_watchdog.sv
// Pause watchdog: counts cycles while enabled and flags the last one before forced resume.
module flow_watchdog #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned TIMER_W = 32;
  localparam logic [TIMER_W-1:0] LAST_COUNT = TIMEOUT_CYCLES - 32'd1;

  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;
  logic               active_c;

  // A zero timeout disables the watchdog entirely; the timer then stays at 0.
  assign active_c = enable && (TIMEOUT_CYCLES != 32'd0);
  assign expire_c = active_c && (timer_q == LAST_COUNT);

  // Next timer value: restart on clear, idle or expiry, otherwise count up.
  always_comb begin
    timer_d = timer_q;
    if (clear || !active_c || expire_c) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  // Timer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/uart_flow_rx_decoder.sv
// Receive-side flow-control decoder: strips stop/start commands, un-escapes data and
// gates the local UART transmitter, with a watchdog that resumes after a lost start byte.
module uart_flow_rx_decoder
  import uart_flow_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
  parameter logic [7:0]  STOP_CODE_P    = STOP_CODE,
  parameter logic [7:0]  START_CODE_P   = START_CODE,
  parameter logic [7:0]  ESC_CODE_P     = ESC_CODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        tx_en,
  output logic        stop_pulse,
  output logic        start_pulse,
  output logic        timeout_pulse,
  output logic [15:0] stop_count
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  flow_state_e        state_q, state_d;
  logic               esc_q, esc_d;
  logic [BYTE_W-1:0]  data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               stop_pulse_q, stop_pulse_d;
  logic               start_pulse_q, start_pulse_d;
  logic               timeout_pulse_q, timeout_pulse_d;
  logic               tx_en_q, tx_en_d;
  logic [COUNT_W-1:0] stop_count_q, stop_count_d;

  logic wd_clear_c;
  logic wd_expire_c;
  logic cmd_seen_c;

  flow_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear_c),
    .enable   (state_q == FLOW_PAUSED),
    .expire_c (wd_expire_c)
  );

  // A stop or start command on this cycle takes priority over a watchdog expiry.
  assign cmd_seen_c = rx_valid && !esc_q &&
                      ((rx_data == STOP_CODE_P) || (rx_data == START_CODE_P));

  // Byte classification, escape handling, flow state and watchdog resume.
  always_comb begin
    state_d         = state_q;
    esc_d           = esc_q;
    data_out_d      = data_out_q;
    data_valid_d    = 1'b0;
    stop_pulse_d    = 1'b0;
    start_pulse_d   = 1'b0;
    timeout_pulse_d = 1'b0;
    stop_count_d    = stop_count_q;
    wd_clear_c      = 1'b0;

    if (rx_valid) begin
      if (esc_q) begin
        data_out_d   = rx_data;
        data_valid_d = 1'b1;
        esc_d        = 1'b0;
      end else if (rx_data == ESC_CODE_P) begin
        esc_d = 1'b1;
      end else if (rx_data == STOP_CODE_P) begin
        state_d      = FLOW_PAUSED;
        wd_clear_c   = 1'b1;
        stop_pulse_d = 1'b1;
        if (stop_count_q != COUNT_MAX) begin
          stop_count_d = stop_count_q + COUNT_W'(1);
        end
      end else if (rx_data == START_CODE_P) begin
        state_d       = FLOW_RUN;
        wd_clear_c    = 1'b1;
        start_pulse_d = 1'b1;
      end else begin
        data_out_d   = rx_data;
        data_valid_d = 1'b1;
      end
    end

    if (wd_expire_c && !cmd_seen_c) begin
      state_d         = FLOW_RUN;
      timeout_pulse_d = 1'b1;
    end

    tx_en_d = (state_d == FLOW_RUN);
  end

  // Output and state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= FLOW_RUN;
      esc_q           <= 1'b0;
      data_out_q      <= '0;
      data_valid_q    <= 1'b0;
      stop_pulse_q    <= 1'b0;
      start_pulse_q   <= 1'b0;
      timeout_pulse_q <= 1'b0;
      tx_en_q         <= 1'b1;
      stop_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      esc_q           <= esc_d;
      data_out_q      <= data_out_d;
      data_valid_q    <= data_valid_d;
      stop_pulse_q    <= stop_pulse_d;
      start_pulse_q   <= start_pulse_d;
      timeout_pulse_q <= timeout_pulse_d;
      tx_en_q         <= tx_en_d;
      stop_count_q    <= stop_count_d;
    end
  end

  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign tx_en         = tx_en_q;
  assign stop_pulse    = stop_pulse_q;
  assign start_pulse   = start_pulse_q;
  assign timeout_pulse = timeout_pulse_q;
  assign stop_count    = stop_count_q;

endmodule

// File: tb/tb_uart_flow_rx_decoder.sv
// Bench for uart_flow_rx_decoder: directed scenarios plus random traffic against a
// cycle-indexed behavioural model (pause deadlines tracked as absolute cycle numbers).
module tb_uart_flow_rx_decoder;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        tx_en;
  logic        stop_pulse;
  logic        start_pulse;
  logic        timeout_pulse;
  logic [15:0] stop_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // behavioural model state
  bit       m_paused;
  bit       m_esc;
  int       m_pause_cyc;
  bit [7:0] m_data;
  bit       m_dv, m_stop_p, m_start_p, m_to_p;
  int       m_count;

  uart_flow_rx_decoder #(
    .TIMEOUT_CYCLES (32'(TO))
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .tx_en         (tx_en),
    .stop_pulse    (stop_pulse),
    .start_pulse   (start_pulse),
    .timeout_pulse (timeout_pulse),
    .stop_count    (stop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_paused = 0; m_esc = 0; m_pause_cyc = 0; m_data = 8'h00;
    m_dv = 0; m_stop_p = 0; m_start_p = 0; m_to_p = 0; m_count = 0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input bit v, input bit [7:0] d, input bit r);
    bit fire, cmd;
    if (r) begin
      model_reset();
      return;
    end
    fire = m_paused && ((cyc - m_pause_cyc) == TO);
    cmd  = v && !m_esc && (d == 8'hFF || d == 8'hFE);
    m_dv = 0; m_stop_p = 0; m_start_p = 0; m_to_p = 0;
    if (v) begin
      if (m_esc) begin
        m_data = d; m_dv = 1; m_esc = 0;
      end else if (d == 8'hFD) begin
        m_esc = 1;
      end else if (d == 8'hFF) begin
        m_paused = 1; m_pause_cyc = cyc; m_stop_p = 1;
        if (m_count < 65535) m_count++;
      end else if (d == 8'hFE) begin
        m_paused = 0; m_start_p = 1;
      end else begin
        m_data = d; m_dv = 1;
      end
    end
    if (fire && !cmd) begin
      m_paused = 0; m_to_p = 1;
    end
  endtask

  // Drive one cycle of inputs, advance model and DUT, then compare every output.
  task automatic step(input bit v, input bit [7:0] d, input bit r);
    rx_valid = v; rx_data = d; rst = r;
    @(posedge clk);
    cyc++;
    model_edge(v, d, r);
    #1;
    chk("tx_en",         32'(tx_en),         32'(!m_paused));
    chk("data_valid",    32'(data_valid),    32'(m_dv));
    chk("data_out",      32'(data_out),      32'(m_data));
    chk("stop_pulse",    32'(stop_pulse),    32'(m_stop_p));
    chk("start_pulse",   32'(start_pulse),   32'(m_start_p));
    chk("timeout_pulse", 32'(timeout_pulse), 32'(m_to_p));
    chk("stop_count",    32'(stop_count),    32'(m_count));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask

  initial begin
    bit [7:0] pass_bytes [3];
    bit [7:0] esc_bytes [3];
    int low;
    pass_bytes[0] = 8'h41; pass_bytes[1] = 8'h00; pass_bytes[2] = 8'h7F;
    esc_bytes[0]  = 8'hFF; esc_bytes[1]  = 8'hFD; esc_bytes[2]  = 8'hFE;
    model_reset();

    // reset state
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    chk("rst_tx_en", 32'(tx_en), 32'd1);
    chk("rst_count", 32'(stop_count), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);

    // data passthrough
    for (int i = 0; i < 3; i++) begin
      step(1, pass_bytes[i], 0);
      chk("pass_data", 32'(data_out), 32'(pass_bytes[i]));
      chk("pass_dv", 32'(data_valid), 32'd1);
      idle(3);
    end

    // stop then start
    step(1, 8'hFF, 0);
    chk("stop_tx_en", 32'(tx_en), 32'd0);
    chk("stop_cnt1", 32'(stop_count), 32'd1);
    idle(10);
    step(1, 8'hFE, 0);
    chk("start_tx_en", 32'(tx_en), 32'd1);
    chk("start_pulse1", 32'(start_pulse), 32'd1);
    idle(2);

    // escape handling
    for (int i = 0; i < 3; i++) begin
      step(1, 8'hFD, 0);
      chk("esc_hold_dv", 32'(data_valid), 32'd0);
      step(1, esc_bytes[i], 0);
      chk("esc_data", 32'(data_out), 32'(esc_bytes[i]));
      chk("esc_tx_en", 32'(tx_en), 32'd1);
    end
    idle(2);

    // watchdog: paused for exactly TO cycles
    step(1, 8'hFF, 0);
    low = 0;
    while (tx_en == 1'b0 && low < 3 * TO) begin
      low++;
      step(0, 8'h00, 0);
    end
    chk("wd_low_cycles", 32'(low), 32'(TO));
    chk("wd_timeout_pulse", 32'(timeout_pulse), 32'd1);
    step(0, 8'h00, 0);
    chk("wd_pulse_width", 32'(timeout_pulse), 32'd0);

    // stop re-sent on the expiry cycle suppresses the timeout
    step(1, 8'hFF, 0);
    idle(TO - 1);
    step(1, 8'hFF, 0);
    chk("restop_no_timeout", 32'(timeout_pulse), 32'd0);
    chk("restop_tx_en", 32'(tx_en), 32'd0);
    low = 0;
    while (tx_en == 1'b0 && low < 3 * TO) begin
      low++;
      step(0, 8'h00, 0);
    end
    chk("restop_low_cycles", 32'(low), 32'(TO));
    idle(2);

    // start byte on the exact expiry cycle
    step(1, 8'hFF, 0);
    idle(TO - 1);
    step(1, 8'hFE, 0);
    chk("coll_start", 32'(start_pulse), 32'd1);
    chk("coll_timeout", 32'(timeout_pulse), 32'd0);
    chk("coll_tx_en", 32'(tx_en), 32'd1);
    idle(2);

    // reset mid-operation discards pause and pending escape
    step(1, 8'hFF, 0);
    step(1, 8'hFD, 0);
    step(0, 8'h00, 1);
    chk("mid_rst_tx_en", 32'(tx_en), 32'd1);
    chk("mid_rst_count", 32'(stop_count), 32'd0);
    step(1, 8'h55, 0);
    chk("mid_rst_data", 32'(data_out), 32'h55);
    chk("mid_rst_dv", 32'(data_valid), 32'd1);
    idle(2);

    // randomized traffic, alternating dense and sparse strobes
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 500; i++) begin
        bit v, r;
        bit [7:0] d;
        int sel;
        v = (blk % 2 == 0) ? ($urandom_range(1, 0) == 1) : ($urandom_range(39, 0) == 0);
        sel = int'($urandom_range(7, 0));
        case (sel)
          0: d = 8'hFF;
          1: d = 8'hFE;
          2: d = 8'hFD;
          default: d = 8'($urandom());
        endcase
        r = ($urandom_range(499, 0) == 0);
        step(v, d, r);
      end
    end

    // stop_count saturation
    step(0, 8'h00, 1);
    for (int i = 0; i < 65537; i++) step(1, 8'hFF, 0);
    chk("sat_count", 32'(stop_count), 32'h0000FFFF);
    step(1, 8'hFE, 0);
    chk("sat_hold", 32'(stop_count), 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_flow_rx_decoder.md
Name: uart_flow_rx_decoder

Overview:
- Far end of the in-band UART flow-control link: parses the received UART byte stream.
- Strips control bytes 0xFF (stop) and 0xFE (start) and drives a tx-enable gate for the local UART transmitter.
- Passes ordinary data bytes through; 0xFD escapes a following literal byte.
- Sits between the UART receiver byte strobe and the rx data FIFO / tx byte scheduler.
- A watchdog auto-resumes transmission if the start byte is lost.

Parameters:
- TIMEOUT_CYCLES, 32'd50_000_000: maximum cycles paused before auto-resume; 0 disables the watchdog.
- STOP_CODE, 8'hFF: pause command byte.
- START_CODE, 8'hFE: resume command byte.
- ESC_CODE, 8'hFD: escape prefix; the next byte is always treated as data.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- data_out  out  8  decoded payload byte
- data_valid  out  1  one-cycle strobe for data_out
- tx_en  out  1  1 = local UART tx may start a new byte
- stop_pulse  out  1  one-cycle pulse, stop command accepted
- start_pulse  out  1  one-cycle pulse, start command accepted
- timeout_pulse  out  1  one-cycle pulse, watchdog forced resume
- stop_count  out  16  number of accepted stop commands, saturating

Behaviour:
- Reset values:
  - data_out=0, data_valid=0, tx_en=1
  - all pulses 0, stop_count=0
  - escape flag clear, watchdog timer 0, state RUN
- Controller is two orthogonal state bits:
  - flow state: RUN / PAUSED; tx_en = (state==RUN)
  - esc_pending: 0 / 1
- On rx_valid with esc_pending=1:
  - data_out<=rx_data, data_valid<=1 next cycle, regardless of value
  - esc_pending<=0; flow state unchanged
- On rx_valid with esc_pending=0:
  - rx_data==ESC_CODE: esc_pending<=1; no output
  - rx_data==STOP_CODE: state<=PAUSED, timer<=0, stop_pulse<=1, stop_count+1 (saturates at 16'hFFFF). Applies even if already PAUSED, which restarts the timer.
  - rx_data==START_CODE: state<=RUN, timer<=0, start_pulse<=1. Pulse is also given if already RUN; state is unchanged in that case.
  - any other value: data_out<=rx_data, data_valid<=1.
- Latency:
  - all outputs are registered, updated in the cycle after the rx_valid edge
  - tx_en falls exactly 1 clk after the stop byte strobe
- esc_pending persists indefinitely across idle cycles until the next rx_valid.
- Watchdog:
  - while PAUSED and TIMEOUT_CYCLES!=0, the timer increments every clk
  - when timer==TIMEOUT_CYCLES-1: state<=RUN, timer<=0, timeout_pulse<=1
  - the timer holds at 0 while RUN
- Simultaneous events (rx_valid and timer expiry in the same cycle):
  - stop byte: stop wins; remain PAUSED, timer restarts, no timeout_pulse
  - start byte: resume via start_pulse only, no timeout_pulse
  - data or escape byte: timeout resume proceeds, byte handled normally
- tx_en is a level gate only; the transmitter finishes any byte already in flight. This block never stalls the rx path (no back-pressure input).
- rx_valid held high on consecutive cycles: each cycle is a separate byte.
- Reset mid-operation (paused, escape pending, or counting): immediately returns to the reset values on the next clk; any pending escape is discarded.

Decomposition:
- Shared package uart_flow_pkg:
  - STOP_CODE, START_CODE, ESC_CODE constants, shared with the encoder end
  - flow state encoding (RUN=1'b0, PAUSED=1'b1)
- One natural sub-module: flow_watchdog
  - loadable timer: inputs clear/enable, output expire pulse
  - parameterised by TIMEOUT_CYCLES
- Byte classification and escape handling stay in the top module.

Test Plan:
- Data passthrough:
  - stimulus: bytes 0x41, 0x00, 0x7F, one strobe each, gaps of 3 clk
  - response: data_valid thrice, data_out matches each byte, tx_en stays 1, no pulses
- Stop then start:
  - stimulus: 0xFF, 10 clk idle, then 0xFE
  - response: tx_en=0 one clk after the 0xFF strobe; stop_pulse once; stop_count=1; tx_en=1 one clk after 0xFE; start_pulse once; no data_valid
- Escape handling:
  - stimulus: 0xFD,0xFF then 0xFD,0xFD then 0xFD,0xFE
  - response: data_out 0xFF, 0xFD, 0xFE as data; tx_en never drops
- Watchdog:
  - stimulus: TIMEOUT_CYCLES=100, send 0xFF, no further bytes
  - response: tx_en=0 for exactly 100 clk, then tx_en=1 with timeout_pulse one clk wide
  - repeat with 0xFF re-sent at cycle 99: expiry suppressed, tx_en stays 0 a further 100 clk
- Collision:
  - stimulus: 0xFE strobe on the exact expiry cycle
  - response: start_pulse=1, timeout_pulse=0, tx_en=1
- Reset mid-operation:
  - stimulus: send 0xFF, 0xFD; pulse rst; then send 0x55
  - response: after reset tx_en=1, stop_count=0; 0x55 output as data with escape cleared
  - stop_count saturation: 65537 stops leave it at 0xFFFF
